// File: rtl/bcd_time_counter_pkg.sv
// Shared constants for the BCD time-of-day counter: BCD limits and set-mode field selects.
package time_pkg;

    localparam int unsigned BCD_W = 8;
    localparam int unsigned SEL_W = 2;

    localparam logic [BCD_W-1:0] BCD_ZERO = 8'h00;
    localparam logic [BCD_W-1:0] BCD_59   = 8'h59;
    localparam logic [BCD_W-1:0] BCD_23   = 8'h23;

    localparam logic [SEL_W-1:0] SEL_SEC  = 2'd0;
    localparam logic [SEL_W-1:0] SEL_MIN  = 2'd1;
    localparam logic [SEL_W-1:0] SEL_HOUR = 2'd2;
    localparam logic [SEL_W-1:0] SEL_NONE = 2'd3;

endpackage

// File: rtl/bcd_time_counter_if.sv
// Control inputs and BCD/event outputs between the controller and the time counter.
interface bcd_time_counter_if;
    import time_pkg::*;

    logic                 slow_clk;
    logic                 run;
    logic                 set_en;
    logic [SEL_W-1:0]     set_sel;
    logic                 set_inc;
    logic [BCD_W-1:0]     sec;
    logic [BCD_W-1:0]     min;
    logic [BCD_W-1:0]     hour;
    logic                 tick_out;
    logic                 hour_chime;
    logic                 day_wrap;

    modport master (
        output slow_clk, run, set_en, set_sel, set_inc,
        input  sec, min, hour, tick_out, hour_chime, day_wrap
    );

    modport slave (
        input  slow_clk, run, set_en, set_sel, set_inc,
        output sec, min, hour, tick_out, hour_chime, day_wrap
    );

endinterface

// File: rtl/bcd_time_counter_digit_pair.sv
// Two-digit BCD counter with programmable terminal value; wrap flags the carry out.
module bcd_digit_pair
    import time_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic [BCD_W-1:0] max,
    output logic [BCD_W-1:0] q,
    output logic             wrap
);

    logic [BCD_W-1:0] q_next;

    // Next BCD value: terminal wraps to zero, units 9 rolls into tens.
    always_comb begin
        q_next = q;
        if (q == max) begin
            q_next = BCD_ZERO;
        end else if (q[3:0] == 4'd9) begin
            q_next = {q[7:4] + 4'd1, 4'd0};
        end else begin
            q_next = {q[7:4], q[3:0] + 4'd1};
        end
    end

    assign wrap = inc & (q == max);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= BCD_ZERO;
        end else if (inc) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/bcd_time_counter.sv
// 24-hour BCD hh:mm:ss counter advanced by rising edges of the divided clock,
// with run/pause, per-field set mode and one-cycle event pulses.
module bcd_time_counter
    import time_pkg::*;
#(
    parameter logic [BCD_W-1:0] HOUR_MAX = BCD_23,
    parameter logic [BCD_W-1:0] SEC_MAX  = BCD_59
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_time_counter_if.slave    bus
);

    logic slow_d;
    logic inc_d;
    logic tick;
    logic inc_edge;
    logic count;
    logic set_hit;
    logic set_sec;
    logic set_min;
    logic set_hour;
    logic sec_inc;
    logic min_inc;
    logic hour_inc;
    logic sec_wrap;
    logic min_wrap;
    logic hour_wrap;

    assign tick     = bus.slow_clk & ~slow_d;
    assign inc_edge = bus.set_inc & ~inc_d;
    assign count    = tick & bus.run & ~bus.set_en;
    assign set_hit  = inc_edge & bus.set_en;

    // Set mode drives exactly one field; SEL_NONE drops the press.
    always_comb begin
        set_sec  = 1'b0;
        set_min  = 1'b0;
        set_hour = 1'b0;
        if (set_hit) begin
            case (bus.set_sel)
                SEL_SEC:  set_sec  = 1'b1;
                SEL_MIN:  set_min  = 1'b1;
                SEL_HOUR: set_hour = 1'b1;
                SEL_NONE: ;
            endcase
        end
    end

    // Carries only ripple while counting; set-mode wraps stay inside their field.
    assign sec_inc  = count | set_sec;
    assign min_inc  = (count & sec_wrap) | set_min;
    assign hour_inc = (count & min_wrap) | set_hour;

    bcd_digit_pair u_sec (
        .clk  (clk),
        .rst  (rst),
        .inc  (sec_inc),
        .max  (SEC_MAX),
        .q    (bus.sec),
        .wrap (sec_wrap)
    );

    bcd_digit_pair u_min (
        .clk  (clk),
        .rst  (rst),
        .inc  (min_inc),
        .max  (SEC_MAX),
        .q    (bus.min),
        .wrap (min_wrap)
    );

    bcd_digit_pair u_hour (
        .clk  (clk),
        .rst  (rst),
        .inc  (hour_inc),
        .max  (HOUR_MAX),
        .q    (bus.hour),
        .wrap (hour_wrap)
    );

    // Edge-detect history resets high so a level already high at release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            slow_d         <= 1'b1;
            inc_d          <= 1'b1;
            bus.tick_out   <= 1'b0;
            bus.hour_chime <= 1'b0;
            bus.day_wrap   <= 1'b0;
        end else begin
            slow_d         <= bus.slow_clk;
            inc_d          <= bus.set_inc;
            bus.tick_out   <= count;
            bus.hour_chime <= count & min_wrap;
            bus.day_wrap   <= count & hour_wrap;
        end
    end

endmodule
